// File: rtl/parking_exit_ctrl_if.sv
// Exit-controller signal bundle: request/sensor/entry inputs and gate/pulse/occupancy outputs.
interface parking_exit_ctrl_if #(
  parameter int unsigned CNT_W = 8
);
  logic             exit_req;
  logic             in_sig;
  logic             out_sig;
  logic             car_entered;
  logic             gate_open;
  logic             exiting;
  logic             deny;
  logic             fault;
  logic [CNT_W-1:0] occupancy;
  logic             empty;
  logic             full;
  logic             ovf_err;

  modport master (
    output exit_req, in_sig, out_sig, car_entered,
    input  gate_open, exiting, deny, fault, occupancy, empty, full, ovf_err
  );

  modport slave (
    input  exit_req, in_sig, out_sig, car_entered,
    output gate_open, exiting, deny, fault, occupancy, empty, full, ovf_err
  );
endinterface

// File: rtl/parking_exit_ctrl.sv
// Exit-side parking controller: walks inner/outer sensors through a pass, drives the
// exit gate with a total pass timeout, and owns the lot occupancy counter.
module parking_exit_ctrl #(
  parameter int unsigned CNT_W    = 8,
  parameter int unsigned CAPACITY = 100,
  parameter int unsigned TIMEOUT  = 1000,
  parameter int unsigned TO_W     = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  parking_exit_ctrl_if.slave    bus
);

  localparam logic [CNT_W-1:0] CAP_V  = CNT_W'(CAPACITY);
  localparam logic [TO_W-1:0]  TO_END = TO_W'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ARMED = 3'd1,
    BOTH  = 3'd2,
    OUTER = 3'd3,
    ABORT = 3'd4
  } state_e;

  state_e           state_q, state_d;
  logic [TO_W-1:0]  timer_q, timer_d;
  logic [CNT_W-1:0] occ_q, occ_d;
  logic             ovf_q, ovf_d;
  logic             req_q;
  logic             gate_q, gate_d;
  logic             exiting_q, exit_done;
  logic             deny_q, deny_d;
  logic             fault_q, fault_d;
  logic             empty_q, full_q;
  logic             req_rise;
  logic             s_none, s_both, s_in_only, s_out_only, timed_out;

  assign req_rise   = bus.exit_req & ~req_q;
  assign s_none     = ~bus.in_sig & ~bus.out_sig;
  assign s_both     =  bus.in_sig &  bus.out_sig;
  assign s_in_only  =  bus.in_sig & ~bus.out_sig;
  assign s_out_only = ~bus.in_sig &  bus.out_sig;
  assign timed_out  = (timer_q == TO_END);

  // Pass sequencing; timeout outranks ARMED/BOTH moves but not a completing exit.
  always_comb begin
    state_d   = state_q;
    timer_d   = timer_q;
    exit_done = 1'b0;
    deny_d    = 1'b0;
    fault_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (req_rise) begin
          if (s_in_only && !empty_q) begin
            state_d = ARMED;
            timer_d = '0;
          end else begin
            deny_d = 1'b1;
          end
        end
      end
      ARMED: begin
        timer_d = timer_q + TO_W'(1);
        if (timed_out) begin
          state_d = ABORT;
          fault_d = 1'b1;
        end else if (s_both) begin
          state_d = BOTH;
        end else if (s_none) begin
          state_d = IDLE;
        end
      end
      BOTH: begin
        timer_d = timer_q + TO_W'(1);
        if (timed_out) begin
          state_d = ABORT;
          fault_d = 1'b1;
        end else if (s_out_only) begin
          state_d = OUTER;
        end else if (s_in_only) begin
          state_d = ARMED;
        end
      end
      OUTER: begin
        timer_d = timer_q + TO_W'(1);
        if (s_none) begin
          state_d   = IDLE;
          exit_done = 1'b1;
        end else if (timed_out) begin
          state_d = ABORT;
          fault_d = 1'b1;
        end else if (s_both) begin
          state_d = BOTH;
        end
      end
      ABORT: begin
        if (s_none) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    gate_d = (state_d == ARMED) || (state_d == BOTH) || (state_d == OUTER);
  end

  // Occupancy: simultaneous entry and exit cancel; saturate and flag at either bound.
  always_comb begin
    occ_d = occ_q;
    ovf_d = ovf_q;
    if (bus.car_entered && !exit_done) begin
      if (occ_q == CAP_V) begin
        ovf_d = 1'b1;
      end else begin
        occ_d = occ_q + CNT_W'(1);
      end
    end else if (exit_done && !bus.car_entered) begin
      if (occ_q == '0) begin
        ovf_d = 1'b1;
      end else begin
        occ_d = occ_q - CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      timer_q   <= '0;
      occ_q     <= '0;
      ovf_q     <= 1'b0;
      req_q     <= 1'b0;
      gate_q    <= 1'b0;
      exiting_q <= 1'b0;
      deny_q    <= 1'b0;
      fault_q   <= 1'b0;
      empty_q   <= 1'b1;
      full_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      timer_q   <= timer_d;
      occ_q     <= occ_d;
      ovf_q     <= ovf_d;
      req_q     <= bus.exit_req;
      gate_q    <= gate_d;
      exiting_q <= exit_done;
      deny_q    <= deny_d;
      fault_q   <= fault_d;
      empty_q   <= (occ_d == '0);
      full_q    <= (occ_d == CAP_V);
    end
  end

  assign bus.gate_open = gate_q;
  assign bus.exiting   = exiting_q;
  assign bus.deny      = deny_q;
  assign bus.fault     = fault_q;
  assign bus.occupancy = occ_q;
  assign bus.empty     = empty_q;
  assign bus.full      = full_q;
  assign bus.ovf_err   = ovf_q;

endmodule

// File: tb/tb_parking_exit_ctrl.sv
// Scenario bench for parking_exit_ctrl: pulse expectations are queued as stimulus is driven
// and a monitor pops them as exiting/deny/fault pulses appear.
module tb_parking_exit_ctrl;

  localparam int unsigned CNT_W    = 8;
  localparam int unsigned CAPACITY = 8;
  localparam int unsigned TIMEOUT  = 20;
  localparam int unsigned TO_W     = 16;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   errors = 0;
  int   checks = 0;

  int exp_exit_occ[$];
  int exp_deny[$];
  int exp_fault[$];

  parking_exit_ctrl_if #(.CNT_W(CNT_W)) bus ();

  parking_exit_ctrl #(
    .CNT_W(CNT_W), .CAPACITY(CAPACITY), .TIMEOUT(TIMEOUT), .TO_W(TO_W)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus.slave)
  );

  always #5 clk = ~clk;

  // Pulse monitor: every pulse must match a queued expectation.
  always @(negedge clk) begin
    if (bus.exiting === 1'b1) begin
      checks++;
      if (exp_exit_occ.size() == 0) begin
        errors++;
        $display("FAIL exit_pulse: unexpected exiting pulse, occupancy=%0d", bus.occupancy);
      end else begin
        int e;
        e = exp_exit_occ.pop_front();
        if (bus.occupancy !== CNT_W'(e) || bus.gate_open !== 1'b0) begin
          errors++;
          $display("FAIL exit_pulse: occupancy=%0d gate=%b, want occupancy=%0d gate=0",
                   bus.occupancy, bus.gate_open, e);
        end
      end
    end
    if (bus.deny === 1'b1) begin
      checks++;
      if (exp_deny.size() == 0) begin
        errors++;
        $display("FAIL deny_pulse: unexpected deny pulse");
      end else begin
        void'(exp_deny.pop_front());
        if (bus.gate_open !== 1'b0) begin
          errors++;
          $display("FAIL deny_pulse: gate=%b want 0", bus.gate_open);
        end
      end
    end
    if (bus.fault === 1'b1) begin
      checks++;
      if (exp_fault.size() == 0) begin
        errors++;
        $display("FAIL fault_pulse: unexpected fault pulse");
      end else begin
        void'(exp_fault.pop_front());
        if (bus.gate_open !== 1'b0) begin
          errors++;
          $display("FAIL fault_pulse: gate=%b want 0", bus.gate_open);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drain(input string name);
    int n = 0;
    while ((exp_exit_occ.size() + exp_deny.size() + exp_fault.size()) != 0 && n < 50) begin
      cyc(1);
      n++;
    end
    checks++;
    if ((exp_exit_occ.size() + exp_deny.size() + exp_fault.size()) != 0) begin
      errors++;
      $display("FAIL %s_drain: %0d exit, %0d deny, %0d fault pulses never seen", name,
               exp_exit_occ.size(), exp_deny.size(), exp_fault.size());
      exp_exit_occ.delete();
      exp_deny.delete();
      exp_fault.delete();
    end
  endtask

  task automatic do_reset();
    bus.exit_req = 0; bus.in_sig = 0; bus.out_sig = 0; bus.car_entered = 0;
    reset = 1'b1;
    cyc(2);
    reset = 1'b0;
    cyc(1);
  endtask

  task automatic enter(input int n);
    bus.car_entered = 1'b1;
    cyc(n);
    bus.car_entered = 1'b0;
  endtask

  // Raise exit_req with only the inner sensor occupied.
  task automatic request();
    bus.exit_req = 0; bus.in_sig = 1; bus.out_sig = 0;
    cyc(1);
    bus.exit_req = 1;
    cyc(1);
    bus.exit_req = 0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if ({bus.gate_open, bus.exiting, bus.deny, bus.fault, bus.empty, bus.full, bus.ovf_err} !== 7'b0000100
        || bus.occupancy !== '0) begin
      errors++;
      $display("FAIL reset: gate,exit,deny,fault,empty,full,ovf=%b occ=%0d want 0000100 occ=0",
               {bus.gate_open, bus.exiting, bus.deny, bus.fault, bus.empty, bus.full, bus.ovf_err},
               bus.occupancy);
    end
  endtask

  task automatic test_exit_pass();
    do_reset();
    enter(3);
    checks++;
    if (bus.occupancy !== 8'd3 || bus.empty !== 1'b0) begin
      errors++;
      $display("FAIL enter3: occ=%0d empty=%b want 3/0", bus.occupancy, bus.empty);
    end
    request();
    checks++;
    if (bus.gate_open !== 1'b1) begin
      errors++;
      $display("FAIL arm_gate: gate=%b want 1", bus.gate_open);
    end
    bus.in_sig = 1; bus.out_sig = 1; cyc(1);
    bus.in_sig = 0; bus.out_sig = 1; cyc(1);
    checks++;
    if (bus.gate_open !== 1'b1 || bus.occupancy !== 8'd3) begin
      errors++;
      $display("FAIL outer_hold: gate=%b occ=%0d want 1/3", bus.gate_open, bus.occupancy);
    end
    bus.in_sig = 0; bus.out_sig = 0;
    exp_exit_occ.push_back(2);
    cyc(1);
    checks++;
    if (bus.gate_open !== 1'b0 || bus.exiting !== 1'b1 || bus.occupancy !== 8'd2) begin
      errors++;
      $display("FAIL exit_edge: gate=%b exiting=%b occ=%0d want 0/1/2",
               bus.gate_open, bus.exiting, bus.occupancy);
    end
    drain("exit_pass");
  endtask

  task automatic test_deny();
    do_reset();
    bus.in_sig = 1; bus.exit_req = 1;
    exp_deny.push_back(1);
    cyc(1);
    checks++;
    if (bus.deny !== 1'b1 || bus.gate_open !== 1'b0) begin
      errors++;
      $display("FAIL deny_empty: deny=%b gate=%b want 1/0", bus.deny, bus.gate_open);
    end
    bus.exit_req = 0;
    drain("deny_empty");
    enter(2);
    bus.in_sig = 0; bus.out_sig = 0;
    cyc(1);
    bus.exit_req = 1;
    exp_deny.push_back(1);
    cyc(1);
    bus.exit_req = 0;
    checks++;
    if (bus.deny !== 1'b1 || bus.gate_open !== 1'b0 || bus.occupancy !== 8'd2) begin
      errors++;
      $display("FAIL deny_nocar: deny=%b gate=%b occ=%0d want 1/0/2",
               bus.deny, bus.gate_open, bus.occupancy);
    end
    drain("deny_nocar");
  endtask

  task automatic test_timeout();
    int n = 0;
    request();
    exp_fault.push_back(1);
    while (bus.fault !== 1'b1 && n < 40) begin
      cyc(1);
      n++;
    end
    checks++;
    if (n != TIMEOUT || bus.gate_open !== 1'b0) begin
      errors++;
      $display("FAIL timeout_cycles: fault after %0d cycles gate=%b, want %0d cycles gate=0",
               n, bus.gate_open, TIMEOUT);
    end
    drain("timeout");
    bus.exit_req = 1; cyc(2); bus.exit_req = 0; cyc(2);
    checks++;
    if (bus.gate_open !== 1'b0) begin
      errors++;
      $display("FAIL abort_ignores_req: gate=%b want 0", bus.gate_open);
    end
    bus.in_sig = 0; cyc(2);
    request();
    checks++;
    if (bus.gate_open !== 1'b1 || bus.occupancy !== 8'd2) begin
      errors++;
      $display("FAIL rearm_after_abort: gate=%b occ=%0d want 1/2", bus.gate_open, bus.occupancy);
    end
    bus.in_sig = 0; cyc(1);
    checks++;
    if (bus.gate_open !== 1'b0) begin
      errors++;
      $display("FAIL withdraw: gate=%b want 0", bus.gate_open);
    end
    drain("abort");
  endtask

  task automatic test_reversal();
    request();
    bus.in_sig = 1; bus.out_sig = 1; cyc(1);
    bus.in_sig = 1; bus.out_sig = 0; cyc(1);
    checks++;
    if (bus.gate_open !== 1'b1) begin
      errors++;
      $display("FAIL reverse_armed: gate=%b want 1", bus.gate_open);
    end
    bus.in_sig = 0; bus.out_sig = 0; cyc(2);
    checks++;
    if (bus.gate_open !== 1'b0 || bus.occupancy !== 8'd2) begin
      errors++;
      $display("FAIL reverse_idle: gate=%b occ=%0d want 0/2", bus.gate_open, bus.occupancy);
    end
    drain("reversal");
  endtask

  task automatic test_simultaneous();
    enter(3);
    request();
    bus.in_sig = 1; bus.out_sig = 1; cyc(1);
    bus.in_sig = 0; bus.out_sig = 1; cyc(1);
    bus.in_sig = 0; bus.out_sig = 0; bus.car_entered = 1;
    exp_exit_occ.push_back(5);
    cyc(1);
    bus.car_entered = 0;
    checks++;
    if (bus.occupancy !== 8'd5 || bus.ovf_err !== 1'b0) begin
      errors++;
      $display("FAIL simul_enter_exit: occ=%0d ovf=%b want 5/0", bus.occupancy, bus.ovf_err);
    end
    drain("simultaneous");
  endtask

  task automatic test_capacity();
    enter(CAPACITY - 5);
    checks++;
    if (bus.occupancy !== CNT_W'(CAPACITY) || bus.full !== 1'b1 || bus.ovf_err !== 1'b0) begin
      errors++;
      $display("FAIL at_capacity: occ=%0d full=%b ovf=%b want %0d/1/0",
               bus.occupancy, bus.full, bus.ovf_err, CAPACITY);
    end
    enter(1);
    cyc(3);
    checks++;
    if (bus.occupancy !== CNT_W'(CAPACITY) || bus.ovf_err !== 1'b1) begin
      errors++;
      $display("FAIL overflow: occ=%0d ovf=%b want %0d/1", bus.occupancy, bus.ovf_err, CAPACITY);
    end
  endtask

  task automatic test_reset_mid();
    request();
    bus.in_sig = 1; bus.out_sig = 1; cyc(1);
    checks++;
    if (bus.gate_open !== 1'b1) begin
      errors++;
      $display("FAIL mid_pre: gate=%b want 1", bus.gate_open);
    end
    reset = 1'b1;
    #2;
    checks++;
    if (bus.gate_open !== 1'b0 || bus.occupancy !== '0 || bus.empty !== 1'b1 || bus.ovf_err !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset_async: gate=%b occ=%0d empty=%b ovf=%b want 0/0/1/0",
               bus.gate_open, bus.occupancy, bus.empty, bus.ovf_err);
    end
    bus.in_sig = 0; bus.out_sig = 0;
    cyc(1);
    reset = 1'b0;
    cyc(5);
    checks++;
    if (bus.gate_open !== 1'b0 || bus.occupancy !== '0) begin
      errors++;
      $display("FAIL mid_after: gate=%b occ=%0d want 0/0", bus.gate_open, bus.occupancy);
    end
    drain("reset_mid");
  endtask

  initial begin
    bus.exit_req = 0; bus.in_sig = 0; bus.out_sig = 0; bus.car_entered = 0;
    test_reset();
    test_exit_pass();
    test_deny();
    test_timeout();
    test_reversal();
    test_simultaneous();
    test_capacity();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/parking_exit_ctrl.md
Name: parking_exit_ctrl

Overview:
Exit-side counterpart to the parking-lot entry path. It accepts a debounced exit request and walks the inner and outer exit sensors through a full pass sequence. It drives the exit gate and owns the lot occupancy counter: the entry FSM's one-cycle `entering` pulse increments the counter and a completed exit decrements it. It sits beside the entry FSM under the parking-lot top and takes its request from a debouncer instance.

Parameters:
CNT_W, 8, width of occupancy counter
CAPACITY, 100, maximum occupancy (must be ≤ 2^CNT_W − 1)
TIMEOUT, 1000, cycles allowed from gate open to completed exit
TO_W, 16, width of timeout counter (2^TO_W > TIMEOUT)

Ports:
clk  input  1  system clock, all logic on rising edge
reset  input  1  asynchronous, active-high; clears all state
exit_req  input  1  debounced exit button (level or pulse; rising edge is used)
in_sig  input  1  inner (lot-side) exit sensor, 1 = vehicle present
out_sig  input  1  outer (street-side) exit sensor, 1 = vehicle present
car_entered  input  1  one-cycle pulse from entry FSM, vehicle admitted
gate_open  output  1  exit gate drive, 1 = open
exiting  output  1  one-cycle pulse, vehicle fully exited
deny  output  1  one-cycle pulse, exit request rejected
fault  output  1  one-cycle pulse, pass timed out
occupancy  output  CNT_W  current vehicle count
empty  output  1  occupancy == 0
full  output  1  occupancy == CAPACITY
ovf_err  output  1  sticky: car_entered while full, or exit while count 0

Behaviour:
- Reset values:
  - state = IDLE, occupancy = 0, timer = 0, ovf_err = 0, req edge register = 0.
  - Outputs: gate_open = 0, exiting = 0, deny = 0, fault = 0, empty = 1, full = 0.
- All outputs are registered; empty and full are decoded from the registered occupancy.
- req_rise = exit_req & ~exit_req_q, where exit_req_q is a 1-cycle delayed copy.
- States: IDLE, ARMED, BOTH, OUTER, ABORT.
  - gate_open = 1 exactly while state ∈ {ARMED, BOTH, OUTER}.
- IDLE:
  - req_rise & in_sig & ~out_sig & ~empty → ARMED; timer cleared to 0.
  - req_rise under any other condition → deny pulse next cycle; stay IDLE.
- ARMED:
  - in_sig & out_sig → BOTH.
  - ~in_sig & ~out_sig → IDLE (vehicle withdrew; no count change).
- BOTH:
  - ~in_sig & out_sig → OUTER.
  - in_sig & ~out_sig → ARMED (vehicle reversing).
- OUTER:
  - ~in_sig & ~out_sig → IDLE; exiting pulse; occupancy decrements by 1.
  - in_sig & out_sig → BOTH.
- Timeout:
  - Timer increments every cycle in ARMED, BOTH and OUTER. It is NOT cleared on moves between those states; it is a total pass budget.
  - When timer == TIMEOUT−1 and no exit completes that cycle → ABORT, with a fault pulse asserted in the same cycle the state register becomes ABORT.
  - Timeout has priority over ARMED/BOTH transitions. A completing OUTER→IDLE transition in the same cycle wins.
- ABORT:
  - gate closed, requests ignored (no deny).
  - Leave to IDLE only when ~in_sig & ~out_sig.
- Latency:
  - exiting, the occupancy update and gate_open falling all appear on the same clock edge.
  - This is one cycle after the sampled sensors clear.
- Occupancy arithmetic:
  - car_entered only → +1. Exit completion only → −1.
  - Both in the same cycle → unchanged, no error.
  - car_entered while full and no simultaneous exit → saturate at CAPACITY, set ovf_err.
  - Exit completion while occupancy == 0 (car_entered raced empty) → hold 0, set ovf_err.
  - ovf_err clears only on reset.
- car_entered is accepted in every state, including ABORT.
- Reset mid-pass: gate closes asynchronously, count returns to 0, no exiting/fault pulse emitted.
- Sensor inputs are assumed already synchronous to clk; no internal debounce on in_sig/out_sig.

Test Plan:
- Reset, 3 car_entered pulses, then exit_req rise with in_sig=1 → gate_open=1 next cycle. Sensors {in,out} = 11 → 01 → 00 → exiting pulse, occupancy 3→2, gate_open=0 on the same edge.
- occupancy=0, exit_req rise with in_sig=1 → deny pulse, gate_open stays 0, state IDLE. Separately, occupancy=2 with in_sig=0 → deny.
- TIMEOUT=20, armed with in_sig held 1 → fault pulse exactly 20 cycles after entry to ARMED, gate_open=0. Stays in ABORT until both sensors are 0, then a new request is accepted.
- Reversal: ARMED → 11 → 10 → 00 → IDLE, occupancy unchanged, no exiting pulse.
- car_entered coincident with an exit completion at occupancy=5 → occupancy stays 5. At occupancy=CAPACITY, car_entered → stays CAPACITY, ovf_err=1 and remains set.
- Assert reset while in BOTH → gate_open=0 immediately (asynchronous), occupancy=0, empty=1, no pulses after release.
